fetch_unit: RTL and testbench

- Instruction fetch stage. Drives the decode stage's instruction/pc inputs and obeys its stall and flush controls.
- Talks to instruction memory over a simple request/response bus with at most one request outstanding.
- Inserts the canonical NOP (addi x0,x0,0) as a bubble whenever no fetched instruction is available.
- Redirects the PC on branch/jump flush.

---
 rtl/fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem bus, NOP bubbles, stall hold and flush redirect.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count / bubble_count outputs.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        insn_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t      state;
  logic [31:0] next_pc;
  logic [31:0] req_pc;
  logic [31:0] hold_insn;
  logic [31:0] hold_pc;
  logic        drop;

  logic [31:0] redirect_aligned;
  logic [31:0] issue_addr;
  logic        issue;
  logic        present_rsp;
  logic        present_buf;
  logic        write_bubble;
  logic        capture;

  assign redirect_aligned = redirect_pc & ~32'h3;

  always_comb begin
    issue        = 1'b0;
    issue_addr   = next_pc;
    present_rsp  = 1'b0;
    present_buf  = 1'b0;
    write_bubble = 1'b0;
    capture      = 1'b0;
    if (flush) begin
      // With nothing outstanding (or the response landing now) the redirect goes out immediately.
      issue      = (state != S_WAIT) || imem_rvalid;
      issue_addr = redirect_aligned;
    end else begin
      case (state)
        S_ISSUE: begin
          issue        = 1'b1;
          write_bubble = !stall;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              issue        = 1'b1;
              write_bubble = !stall;
            end else if (!stall) begin
              issue       = 1'b1;
              present_rsp = 1'b1;
            end else begin
              capture = 1'b1;
            end
          end else begin
            write_bubble = !stall;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            issue       = 1'b1;
            present_buf = 1'b1;
          end
        end
        default: begin
          issue = 1'b1;
        end
      endcase
    end
  end

  assign imem_req  = issue && !rst;
  assign imem_addr = issue_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_ISSUE;
      next_pc     <= RESET_PC & ~32'h3;
      req_pc      <= RESET_PC & ~32'h3;
      hold_insn   <= NOP_INSN;
      hold_pc     <= RESET_PC;
      drop        <= 1'b0;
      instruction <= NOP_INSN;
      pc          <= RESET_PC;
      insn_valid  <= 1'b0;
    end else begin
      if (issue) begin
        req_pc  <= issue_addr;
        next_pc <= issue_addr + 32'd4;
        state   <= S_WAIT;
      end else if (flush) begin
        next_pc <= redirect_aligned;
      end else if (capture) begin
        hold_insn <= imem_rdata;
        hold_pc   <= req_pc;
        state     <= S_HOLD;
      end

      if (flush) begin
        instruction <= NOP_INSN;
        insn_valid  <= 1'b0;
        hold_insn   <= NOP_INSN;
        hold_pc     <= redirect_aligned;
        // A flush that cannot issue leaves a stale response in flight that must be thrown away.
        drop        <= !issue;
      end else begin
        if (issue) begin
          drop <= 1'b0;
        end
        if (present_rsp) begin
          instruction <= imem_rdata;
          pc          <= req_pc;
          insn_valid  <= 1'b1;
        end else if (present_buf) begin
          instruction <= hold_insn;
          pc          <= hold_pc;
          insn_valid  <= 1'b1;
        end else if (write_bubble) begin
          instruction <= NOP_INSN;
          insn_valid  <= 1'b0;
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count  <= 32'd0;
      bubble_count <= 32'd0;
    end else begin
      if (present_rsp || present_buf) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (write_bubble || (flush && !stall)) begin
        bubble_count <= bubble_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: tabulated per-cycle expectations against a variable-latency memory.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        insn_valid;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  logic        rst_w = 1'b1;
  logic        imem_req_w;
  logic [31:0] imem_addr_w;
  logic        imem_rvalid_w = 1'b0;
  logic [31:0] imem_rdata_w = 32'h0;
  logic [31:0] instruction_w;
  logic [31:0] pc_w;
  logic        insn_valid_w;

  int errors = 0;
  int checks = 0;
  int lat = 1;
  int viol = 0;

  fetch_unit u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc(pc), .insn_valid(insn_valid),
    .stall(stall), .flush(flush), .redirect_pc(redirect_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst_w),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_rvalid(imem_rvalid_w), .imem_rdata(imem_rdata_w),
    .instruction(instruction_w), .pc(pc_w), .insn_valid(insn_valid_w),
    .stall(1'b0), .flush(1'b0), .redirect_pc(32'h0)
  );

  // Observation: {req, addr (0 when no req), valid, pc, instruction}.
  logic [97:0] obs;
  logic [97:0] obs_w;
  assign obs   = {imem_req, imem_req ? imem_addr : 32'h0, insn_valid, pc, instruction};
  assign obs_w = {imem_req_w, imem_req_w ? imem_addr_w : 32'h0, insn_valid_w, pc_w, instruction_w};

  function automatic logic [97:0] ev(input bit r, input logic [31:0] a, input bit v,
                                     input logic [31:0] p, input logic [31:0] n);
    return {r, a, v, p, n};
  endfunction

  // Memory: response 'lat' cycles after the request, data = addr + 0x100.
  int          m_cnt = 0;
  logic [31:0] m_addr = 32'h0;
  always @(posedge clk) begin
    if (rst) begin
      m_cnt       <= 0;
      imem_rvalid <= 1'b0;
    end else if (imem_req) begin
      if (lat == 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= imem_addr + 32'h100;
        m_cnt       <= 0;
      end else begin
        imem_rvalid <= 1'b0;
        m_cnt       <= lat - 1;
        m_addr      <= imem_addr;
      end
    end else if (m_cnt == 1) begin
      imem_rvalid <= 1'b1;
      imem_rdata  <= m_addr + 32'h100;
      m_cnt       <= 0;
    end else begin
      imem_rvalid <= 1'b0;
      if (m_cnt > 0) m_cnt <= m_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (rst_w) begin
      imem_rvalid_w <= 1'b0;
    end else begin
      imem_rvalid_w <= imem_req_w;
      imem_rdata_w  <= imem_addr_w + 32'h100;
    end
  end

  // Bus protocol monitor: no request while one is outstanding and not completing; aligned addresses.
  logic outstanding = 1'b0;
  always @(posedge clk) begin
    if (rst)           outstanding <= 1'b0;
    else if (imem_req) outstanding <= 1'b1;
    else if (imem_rvalid) outstanding <= 1'b0;
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req && outstanding && !imem_rvalid) viol++;
      if (imem_req && (imem_addr[1:0] != 2'b00)) viol++;
    end
  end

  task automatic show();
    $display("cyc t=%0t req=%b addr=%h rvalid=%b valid=%b pc=%h insn=%h",
             $time, imem_req, imem_addr, imem_rvalid, insn_valid, pc, instruction);
  endtask

  task automatic next_cyc(input bit s, input bit f, input logic [31:0] r);
    @(posedge clk);
    #1;
    stall = s;
    flush = f;
    redirect_pc = r;
    #1;
    show();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    redirect_pc = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    show();
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    show();
    checks++;
    if (obs !== ev(0, 32'h0, 0, 32'h0, NOP)) begin
      errors++;
      $display("FAIL reset: got req=%b valid=%b pc=%h insn=%h want req=0 valid=0 pc=0 insn=%h",
               imem_req, insn_valid, pc, instruction, NOP);
    end
  endtask

  task automatic test_back_to_back();
    logic [97:0] e [5];
    e = '{ev(1, 32'h0, 0, 32'h0, NOP), ev(1, 32'h4, 0, 32'h0, NOP),
          ev(1, 32'h8, 1, 32'h0, 32'h100), ev(1, 32'hC, 1, 32'h4, 32'h104),
          ev(1, 32'h10, 1, 32'h8, 32'h108)};
    lat = 1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cyc(0, 0, 32'h0);
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL back_to_back c%0d: got req=%b addr=%h valid=%b pc=%h insn=%h want req=%b addr=%h valid=%b pc=%h insn=%h",
                 i, obs[97], obs[96:65], obs[64], obs[63:32], obs[31:0],
                 e[i][97], e[i][96:65], e[i][64], e[i][63:32], e[i][31:0]);
      end
    end
  endtask

  task automatic test_stall();
    logic [97:0] e [9];
    bit st [9];
    e = '{ev(1, 32'h0, 0, 32'h0, NOP), ev(1, 32'h4, 0, 32'h0, NOP),
          ev(1, 32'h8, 1, 32'h0, 32'h100), ev(0, 32'h0, 1, 32'h4, 32'h104),
          ev(0, 32'h0, 1, 32'h4, 32'h104), ev(0, 32'h0, 1, 32'h4, 32'h104),
          ev(1, 32'hC, 1, 32'h4, 32'h104), ev(1, 32'h10, 1, 32'h8, 32'h108),
          ev(1, 32'h14, 1, 32'hC, 32'h10C)};
    st = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    lat = 1;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i > 0) next_cyc(st[i], 0, 32'h0);
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL stall c%0d: got req=%b addr=%h valid=%b pc=%h insn=%h want req=%b addr=%h valid=%b pc=%h insn=%h",
                 i, obs[97], obs[96:65], obs[64], obs[63:32], obs[31:0],
                 e[i][97], e[i][96:65], e[i][64], e[i][63:32], e[i][31:0]);
      end
    end
  endtask

  task automatic test_latency();
    logic [97:0] e [8];
    e = '{ev(1, 32'h0, 0, 32'h0, NOP), ev(0, 32'h0, 0, 32'h0, NOP),
          ev(0, 32'h0, 0, 32'h0, NOP), ev(1, 32'h4, 0, 32'h0, NOP),
          ev(0, 32'h0, 1, 32'h0, 32'h100), ev(0, 32'h0, 0, 32'h0, NOP),
          ev(1, 32'h8, 0, 32'h0, NOP), ev(0, 32'h0, 1, 32'h4, 32'h104)};
    lat = 3;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) next_cyc(0, 0, 32'h0);
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL latency c%0d: got req=%b addr=%h valid=%b pc=%h insn=%h want req=%b addr=%h valid=%b pc=%h insn=%h",
                 i, obs[97], obs[96:65], obs[64], obs[63:32], obs[31:0],
                 e[i][97], e[i][96:65], e[i][64], e[i][63:32], e[i][31:0]);
      end
    end
  endtask

  task automatic test_flush();
    logic [97:0] e [8];
    bit fl [8];
    e = '{ev(1, 32'h0, 0, 32'h0, NOP), ev(0, 32'h0, 0, 32'h0, NOP),
          ev(1, 32'h4, 0, 32'h0, NOP), ev(0, 32'h0, 1, 32'h0, 32'h100),
          ev(1, 32'h200, 0, 32'h0, NOP), ev(0, 32'h0, 0, 32'h0, NOP),
          ev(1, 32'h204, 0, 32'h0, NOP), ev(0, 32'h0, 1, 32'h200, 32'h300)};
    fl = '{0, 0, 0, 1, 0, 0, 0, 0};
    lat = 2;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) next_cyc(0, fl[i], 32'h203);
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL flush c%0d: got req=%b addr=%h valid=%b pc=%h insn=%h want req=%b addr=%h valid=%b pc=%h insn=%h",
                 i, obs[97], obs[96:65], obs[64], obs[63:32], obs[31:0],
                 e[i][97], e[i][96:65], e[i][64], e[i][63:32], e[i][31:0]);
      end
    end
  endtask

  task automatic test_flush_hold();
    logic [97:0] e [7];
    bit st [7];
    bit fl [7];
    e = '{ev(1, 32'h0, 0, 32'h0, NOP), ev(1, 32'h4, 0, 32'h0, NOP),
          ev(1, 32'h8, 1, 32'h0, 32'h100), ev(0, 32'h0, 1, 32'h4, 32'h104),
          ev(1, 32'h400, 1, 32'h4, 32'h104), ev(1, 32'h404, 0, 32'h4, NOP),
          ev(1, 32'h408, 1, 32'h400, 32'h500)};
    st = '{0, 0, 0, 1, 1, 0, 0};
    fl = '{0, 0, 0, 0, 1, 0, 0};
    lat = 1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) next_cyc(st[i], fl[i], 32'h400);
      checks++;
      if (obs !== e[i]) begin
        errors++;
        $display("FAIL flush_hold c%0d: got req=%b addr=%h valid=%b pc=%h insn=%h want req=%b addr=%h valid=%b pc=%h insn=%h",
                 i, obs[97], obs[96:65], obs[64], obs[63:32], obs[31:0],
                 e[i][97], e[i][96:65], e[i][64], e[i][63:32], e[i][31:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    lat = 1;
    do_reset();
    next_cyc(0, 0, 32'h0);
    next_cyc(0, 0, 32'h0);
    next_cyc(0, 0, 32'h0);
    checks++;
    if (obs !== ev(1, 32'hC, 1, 32'h4, 32'h104)) begin
      errors++;
      $display("FAIL reset_mid_pre: got valid=%b pc=%h insn=%h want valid=1 pc=4 insn=104",
               insn_valid, pc, instruction);
    end
    rst = 1'b1;
    @(posedge clk);
    #2;
    show();
    checks++;
    if (obs !== ev(0, 32'h0, 0, 32'h0, NOP)) begin
      errors++;
      $display("FAIL reset_mid: got req=%b valid=%b pc=%h insn=%h want req=0 valid=0 pc=0 insn=%h",
               imem_req, insn_valid, pc, instruction, NOP);
    end
    rst = 1'b0;
    #1;
    show();
    checks++;
    if (obs !== ev(1, 32'h0, 0, 32'h0, NOP)) begin
      errors++;
      $display("FAIL reset_mid_restart: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    logic [97:0] e [4];
    e = '{ev(1, 32'hFFFF_FFF8, 0, 32'hFFFF_FFF8, NOP),
          ev(1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFF8, NOP),
          ev(1, 32'h0000_0000, 1, 32'hFFFF_FFF8, 32'h0000_00F8),
          ev(1, 32'h0000_0004, 1, 32'hFFFF_FFFC, 32'h0000_00FC)};
    rst_w = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_w = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #2;
      end
      $display("wrap t=%0t req=%b addr=%h valid=%b pc=%h insn=%h",
               $time, imem_req_w, imem_addr_w, insn_valid_w, pc_w, instruction_w);
      checks++;
      if (obs_w !== e[i]) begin
        errors++;
        $display("FAIL wrap c%0d: got req=%b addr=%h valid=%b pc=%h insn=%h want req=%b addr=%h valid=%b pc=%h insn=%h",
                 i, obs_w[97], obs_w[96:65], obs_w[64], obs_w[63:32], obs_w[31:0],
                 e[i][97], e[i][96:65], e[i][64], e[i][63:32], e[i][31:0]);
      end
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL protocol: got %0d bus violations want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_latency();
    test_flush();
    test_flush_hold();
    test_reset_mid();
    test_wrap();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
